// File: rtl/sd_host_pkg.sv
// Shared types and defaults for the SD host run sequencer.
package sd_host_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sd_watchdog.sv
// WAIT-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th consecutive enabled cycle is reached.
module sd_watchdog #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // count holds the number of enabled cycles already completed
  assign expired = enable && (count == W'(LIMIT - 1));

  // counter: cleared whenever outside the watched window, holds at expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  count <= '0;
    else if (clear)             count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/sd_host_sequencer.sv
// SD host run sequencer: accepts a batch of N runs, pulses xs for each run,
// waits for fin, inserts a one-cycle GAP between runs and pulses done at the
// end. Optional WAIT watchdog enabled by defining SD_HOST_TIMEOUT_EN.
module sd_host_sequencer
  import sd_host_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_runs,
  input  logic             abort,
  output logic             xs,
  input  logic             fin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] runs_done,
  output logic             timeout_err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] runs_inc;
  logic             accept;
  logic             run_fin;

  // runs_done never exceeds target, so the increment cannot wrap
  assign runs_inc = runs_done + 1'b1;

`ifdef SD_HOST_TIMEOUT_EN
  logic wd_expired;
  logic wd_fire;

  sd_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != WAIT),
    .enable  (state == WAIT),
    .expired (wd_expired)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
`endif

  // Moore outputs decoded from the state
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign xs        = (state == START);
  assign done      = (state == DONE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: abort beats fin, fin beats watchdog expiry
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_fin   = 1'b0;
`ifdef SD_HOST_TIMEOUT_EN
    wd_fire   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = (cmd_runs == '0) ? DONE : START;
        end
      end
      START: state_nxt = abort ? DONE : WAIT;
      WAIT: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (fin) begin
          run_fin   = 1'b1;
          state_nxt = (runs_inc == target) ? DONE : GAP;
        end
`ifdef SD_HOST_TIMEOUT_EN
        else if (wd_expired) begin
          wd_fire   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      GAP:     state_nxt = abort ? DONE : START;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // target latched at acceptance; runs_done cleared there and bumped per fin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target    <= '0;
      runs_done <= '0;
    end else if (accept) begin
      target    <= cmd_runs;
      runs_done <= '0;
    end else if (run_fin) begin
      runs_done <= runs_inc;
    end
  end

`ifdef SD_HOST_TIMEOUT_EN
  // sticky watchdog flag, cleared only by the next accepted command
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        timeout_err <= 1'b0;
    else if (accept)  timeout_err <= 1'b0;
    else if (wd_fire) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_host_sequencer.sv
// Self-checking bench for sd_host_sequencer. A batch-level model predicts
// the xs pulse cycles, the done cycle, runs_done and timeout_err from the
// per-run responder delays; a responder drives fin from the observed xs.
// Timeout expectations follow SD_HOST_TIMEOUT_EN when it is defined.
module tb_sd_host_sequencer;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 32;
`ifdef SD_HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready, abort, xs, fin, busy, done, timeout_err;
  logic [CNT_W-1:0] cmd_runs, runs_done;

  int n_chk  = 0;
  int n_fail = 0;
  int dq[$];

  always #5 clk = ~clk;

  sd_host_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_runs    (cmd_runs),
    .abort       (abort),
    .xs          (xs),
    .fin         (fin),
    .busy        (busy),
    .done        (done),
    .runs_done   (runs_done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one batch of n runs with responder delays dq[0..n-1].
  // abort_run: run index whose WAIT gets abort at xs+abort_off (0 = none).
  // rst_run: run index at whose xs pulse reset is asserted (0 = none).
  // spur: extra fin in each START cycle and abort in the DONE cycle.
  task automatic run_batch(input string nm, input int n, input int abort_run,
                           input int abort_off, input int rst_run, input bit spur);
    int xs_exp[$];
    int done_exp, runs_exp, terr_exp, x;
    int t, seen, fin_at, abort_at, done_at, rd_at, te_at;
    // batch model: cycle 1 is the first cycle after the acceptance edge
    x = 1; done_exp = -1; runs_exp = 0; terr_exp = 0;
    if (n == 0) done_exp = 1;
    for (int i = 1; i <= n && done_exp < 0; i++) begin
      xs_exp.push_back(x);
      if (i == abort_run) begin
        done_exp = x + abort_off + 1;
      end else if (TO_EN && dq[i-1] > TIMEOUT) begin
        done_exp = x + TIMEOUT + 1;
        terr_exp = 1;
      end else begin
        runs_exp = i;
        if (i == n) done_exp = x + dq[i-1] + 1;
        else        x = x + dq[i-1] + 2;
      end
    end
    // issue the command
    @(negedge clk);
    fin = 1'b0; abort = 1'b0;
    check({nm, "/cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_runs = CNT_W'(n);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 1; seen = 0; fin_at = -1; abort_at = -1; done_at = -1; rd_at = -1; te_at = -1;
    while (done_at < 0 && t < 3000) begin
      fin = 1'b0; abort = 1'b0;
      if (t == 1) begin
        check({nm, "/runs_clr"}, runs_done, 0);
        check({nm, "/terr_clr"}, timeout_err, 0);
      end
      if (xs && rst_run != 0 && seen + 1 == rst_run) begin
        reset = 1'b1;
        #1;
        check({nm, "/rst_xs"}, xs, 0);
        check({nm, "/rst_busy"}, busy, 0);
        check({nm, "/rst_ready"}, cmd_ready, 1);
        check({nm, "/rst_runs"}, runs_done, 0);
        repeat (2) begin
          @(negedge clk);
          check({nm, "/rst_nodone"}, done, 0);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check({nm, "/post_rst_nodone"}, done, 0);
          check({nm, "/post_rst_ready"}, cmd_ready, 1);
        end
        return;
      end
      check({nm, "/busy"}, busy, 1);
      if (xs) begin
        check({nm, "/xs_cycle"}, t, (seen < xs_exp.size()) ? xs_exp[seen] : -1);
        seen++;
        if (seen <= dq.size()) fin_at = t + dq[seen-1];
        if (seen == abort_run) abort_at = t + abort_off;
        if (spur) fin = 1'b1;
      end
      if (t == fin_at)   fin = 1'b1;
      if (t == abort_at) abort = 1'b1;
      if (done) begin
        done_at = t; rd_at = runs_done; te_at = timeout_err;
        if (spur) abort = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    fin = 1'b0; abort = 1'b0;
    check({nm, "/done_cycle"}, done_at, done_exp);
    check({nm, "/xs_count"}, seen, xs_exp.size());
    check({nm, "/runs_done"}, rd_at, runs_exp);
    check({nm, "/timeout_err"}, te_at, terr_exp);
    check({nm, "/done_width"}, done, 0);
    check({nm, "/idle_ready"}, cmd_ready, 1);
    check({nm, "/idle_busy"}, busy, 0);
    check({nm, "/idle_terr"}, timeout_err, terr_exp);
  endtask

  initial begin
    int n, ar, ao;
    reset = 1'b1; cmd_valid = 1'b0; cmd_runs = '0; abort = 1'b0; fin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/xs", xs, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/runs_done", runs_done, 0);
    check("reset/timeout_err", timeout_err, 0);
    check("reset/cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // abort and fin while idle are ignored
    abort = 1'b1; fin = 1'b1;
    @(negedge clk);
    abort = 1'b0; fin = 1'b0;
    check("idle_abort/busy", busy, 0);
    check("idle_abort/ready", cmd_ready, 1);

    dq = '{12};
    run_batch("single", 1, 0, 0, 0, 1'b0);

    dq = '{$urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9)};
    run_batch("batch3", 3, 0, 0, 0, 1'b0);

    dq = {};
    run_batch("zero", 0, 0, 0, 0, 1'b0);

    dq = '{TIMEOUT + 6};
    run_batch("timeout", 1, 0, 0, 0, 1'b0);

    dq = '{TIMEOUT};
    run_batch("to_boundary", 1, 0, 0, 0, 1'b0);

    // abort in WAIT of run 2 of 4, coinciding with fin (abort wins)
    dq = '{4, 3, 5, 5};
    run_batch("abort", 4, 2, 3, 0, 1'b0);

    dq = '{3, 3, 3, 3};
    run_batch("reset_mid", 4, 0, 0, 2, 1'b0);

    dq = {};
    for (int i = 0; i < 255; i++) dq.push_back(1);
    run_batch("max_runs", 255, 0, 0, 0, 1'b1);

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 5);
      dq = {};
      for (int i = 0; i < n; i++) dq.push_back($urandom_range(1, 20));
      ar = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      ao = (ar != 0) ? $urandom_range(1, dq[ar-1]) : 0;
      run_batch("random", n, ar, ao, 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
